// File: rtl/io_cond_pkg.sv
// io_cond_pkg: shared input-conditioning constants and helpers.
// Default timings assume the 65 MHz system clock.
package io_cond_pkg;

  localparam int DB_COUNT_DEF      = 1_000_000;
  localparam int REPEAT_DELAY_DEF  = 32_500_000;
  localparam int REPEAT_PERIOD_DEF = 6_500_000;

  // Bits needed to hold the values 0..v inclusive.
  function automatic int cnt_w(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/db_channel.sv
// db_channel: one synchronized, debounced input with edge pulses
// and optional hold-to-repeat press pulses.
module db_channel
  import io_cond_pkg::*;
#(
  parameter int DB_COUNT      = DB_COUNT_DEF,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic noisy_in,
  output logic clean_out,
  output logic rise_out,
  output logic fall_out,
  output logic press_out
);

  localparam int DB_W = cnt_w(DB_COUNT);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_COUNT);

  logic            sync1_q;
  logic            sync2_q;
  logic            cand_q, cand_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            clean_q, clean_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  // Restart the stability count on any change; accept once saturated.
  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == DB_MAX) begin
      clean_d = cand_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    rise_d = clean_d & ~clean_q;
    fall_d = ~clean_d & clean_q;
  end

  // Synchronizer, debounce state and registered edge pulses.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cand_q  <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= noisy_in;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_out = clean_q;
  assign rise_out  = rise_q;
  assign fall_out  = fall_q;

  if (REPEAT_EN != 0) begin : g_rep
    localparam int RW = cnt_w(max_i(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [RW-1:0] DLY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] PER = RW'(REPEAT_PERIOD);

    logic [RW-1:0] rcnt_q, rcnt_d, rnext;
    logic          first_q, first_d;
    logic          press_q, press_d;

    // Count from the rise; the first target is the delay,
    // every later one the period. Leaving the high level
    // (or a fresh rise) restarts the schedule.
    always_comb begin
      rnext   = rcnt_q + 1'b1;
      rcnt_d  = rcnt_q;
      first_d = first_q;
      press_d = rise_d;
      if (!clean_d || rise_d) begin
        rcnt_d  = '0;
        first_d = 1'b0;
      end else if (rnext == (first_q ? PER : DLY)) begin
        rcnt_d  = '0;
        first_d = 1'b1;
        press_d = 1'b1;
      end else begin
        rcnt_d = rnext;
      end
    end

    // Repeat schedule state and registered press pulse.
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        rcnt_q  <= '0;
        first_q <= 1'b0;
        press_q <= 1'b0;
      end else begin
        rcnt_q  <= rcnt_d;
        first_q <= first_d;
        press_q <= press_d;
      end
    end

    assign press_out = press_q;
  end else begin : g_norep
    assign press_out = rise_q;
  end

endmodule

// File: rtl/multi_debounce.sv
// multi_debounce: N_CH independent debounce channels sharing
// one reset whose release is synchronized to clk_in.
module multi_debounce
  import io_cond_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int DB_COUNT      = DB_COUNT_DEF,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [N_CH-1:0] noisy_in,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_out,
  output logic [N_CH-1:0] fall_out,
  output logic [N_CH-1:0] press_out
);

  logic rst_meta_q;
  logic rst_sync_q;

  // Assert immediately, release through two flops.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= rst_meta_q;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    db_channel #(
      .DB_COUNT      (DB_COUNT),
      .REPEAT_EN     (REPEAT_EN),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk_in    (clk_in),
      .rst_in    (rst_sync_q),
      .noisy_in  (noisy_in[i]),
      .clean_out (clean_out[i]),
      .rise_out  (rise_out[i]),
      .fall_out  (fall_out[i]),
      .press_out (press_out[i])
    );
  end

endmodule

// File: tb/tb_multi_debounce.sv
// tb_multi_debounce: randomized + directed scoreboard bench for
// multi_debounce, with and without hold-to-repeat.
module tb_multi_debounce;

  localparam int NC = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NC-1:0] noisy = '0;

  logic [NC-1:0] c1, r1, f1, p1;
  logic [NC-1:0] c0, r0, f0, p0;

  multi_debounce #(
    .N_CH(NC), .DB_COUNT(DB), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk_in(clk), .rst_in(rst), .noisy_in(noisy),
    .clean_out(c1), .rise_out(r1),
    .fall_out(f1), .press_out(p1)
  );

  multi_debounce #(
    .N_CH(NC), .DB_COUNT(DB), .REPEAT_EN(0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_nr (
    .clk_in(clk), .rst_in(rst), .noisy_in(noisy),
    .clean_out(c0), .rise_out(r0),
    .fall_out(f0), .press_out(p0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NC-1:0] c;
    logic [NC-1:0] r;
    logic [NC-1:0] f;
    logic [NC-1:0] p1;
    logic [NC-1:0] p0;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: raw samples per edge, level, age.
  bit h[NC][$];
  bit mclean[NC];
  int age[NC];
  bit rst_p1 = 1'b1;
  bit rst_p2 = 1'b1;

  // Model: a new level is accepted once the raw input seen at
  // edges k-DB-3 .. k-2 is all equal; repeats at age RD+n*RP.
  always @(posedge clk) begin : model
    logic [NC-1:0] raw_s;
    logic rst_s;
    exp_t e;
    bit active, stable, nc, rise, fall, rep;
    raw_s = noisy;
    rst_s = rst;
    #3;
    active = !rst_s && !rst_p1 && !rst_p2 && !rst;
    rst_p2 = rst_p1;
    rst_p1 = rst_s;
    e = '0;
    for (int ch = 0; ch < NC; ch++) begin
      if (!active) begin
        h[ch] = {};
        for (int j = 0; j < DB + 4; j++) h[ch].push_back(1'b0);
        mclean[ch] = 1'b0;
        age[ch] = 0;
      end else begin
        h[ch].push_back(raw_s[ch]);
        void'(h[ch].pop_front());
        stable = 1'b1;
        for (int j = 1; j < DB + 2; j++)
          if (h[ch][j] != h[ch][0]) stable = 1'b0;
        nc = stable ? h[ch][0] : mclean[ch];
        rise = nc && !mclean[ch];
        fall = !nc && mclean[ch];
        if (rise) age[ch] = 0;
        else if (nc) age[ch]++;
        rep = nc && !rise && age[ch] >= RD &&
              ((age[ch] - RD) % RP) == 0;
        e.c[ch]  = nc;
        e.r[ch]  = rise;
        e.f[ch]  = fall;
        e.p1[ch] = rise || rep;
        e.p0[ch] = rise;
        mclean[ch] = nc;
      end
    end
    sb.push_back(e);
  end

  task automatic chk(input string nm,
                     input logic [NC-1:0] act,
                     input logic [NC-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%b want=%b",
               nm, $time, act, want);
    end
  endtask

  // Monitor: every cycle presents a full set of outputs.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("clean_rep", c1, e.c);
      chk("rise_rep",  r1, e.r);
      chk("fall_rep",  f1, e.f);
      chk("press_rep", p1, e.p1);
      chk("clean_nr",  c0, e.c);
      chk("rise_nr",   r0, e.r);
      chk("fall_nr",   f0, e.f);
      chk("press_nr",  p0, e.p0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int hold[NC];
  bit pat[5];

  initial begin
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tick(3);
    rst = 1'b0;
    tick(4);
    // single channel press and hold
    noisy[0] = 1'b1;
    tick(15);
    // short glitch on ch1
    noisy[1] = 1'b1;
    tick(3);
    noisy[1] = 1'b0;
    tick(12);
    // hold-to-repeat on ch2, then release
    noisy[2] = 1'b1;
    tick(30);
    noisy[2] = 1'b0;
    tick(15);
    // simultaneous rise on ch0 and ch3
    noisy[0] = 1'b0;
    tick(12);
    noisy[0] = 1'b1;
    noisy[3] = 1'b1;
    tick(12);
    noisy[0] = 1'b0;
    noisy[3] = 1'b0;
    tick(12);
    // bounce then settle
    for (int i = 0; i < 5; i++) begin
      noisy[0] = pat[i];
      tick(1);
    end
    noisy[0] = 1'b1;
    tick(15);
    // just-too-short and just-long-enough holds
    noisy[3] = 1'b1;
    tick(DB + 1);
    noisy[3] = 1'b0;
    tick(10);
    noisy[3] = 1'b1;
    tick(DB + 2);
    noisy[3] = 1'b0;
    tick(12);
    // reset mid-repeat (ch2) and mid-count (ch1), inputs held
    noisy[2] = 1'b1;
    tick(16);
    noisy[1] = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(25);
    noisy = '0;
    tick(12);
    // randomized holds with occasional reset
    for (int ch = 0; ch < NC; ch++) hold[ch] = 1;
    for (int t = 0; t < 3000; t++) begin
      for (int ch = 0; ch < NC; ch++) begin
        hold[ch]--;
        if (hold[ch] <= 0) begin
          noisy[ch] = ~noisy[ch];
          if ($urandom_range(0, 3) == 0)
            hold[ch] = int'($urandom_range(1, DB + 2));
          else
            hold[ch] = int'($urandom_range(DB + 2, 40));
        end
      end
      rst = ($urandom_range(0, 399) == 0);
      tick(1);
    end
    rst = 1'b0;
    noisy = '0;
    tick(20);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain t=%0t got=%0d want=0",
               $time, sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
